// File: rtl/shift_arbiter.sv
// Arbitrates NREQ requesters onto one shared, external barrel shifter.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has the highest priority.
module shift_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned SW   = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*DW-1:0]       req_data_i,
  input  logic [NREQ*SW-1:0]       req_amt_i,
  output logic [DW-1:0]            sh_datain_o,
  output logic [SW-1:0]            sh_shift_amt_o,
  input  logic [DW-1:0]            sh_shifted_data_i,
  output logic                     rsp_valid_o,
  output logic [$clog2(NREQ)-1:0]  rsp_id_o,
  output logic [DW-1:0]            rsp_data_o,
  input  logic                     rsp_ready_i
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StShift, StResp} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   op_data_q;
  logic [SW-1:0]   op_amt_q;
  logic [IW-1:0]   id_q;
  logic [DW-1:0]   rsp_data_q;

  logic            grant_valid;
  logic [IW-1:0]   grant_id;
  logic            xfer;

  logic [DW-1:0]   data_arr [NREQ];
  logic [SW-1:0]   amt_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : gen_unpack
    assign data_arr[g] = req_data_i[g*DW +: DW];
    assign amt_arr[g]  = req_amt_i[g*SW +: SW];
  end

`ifdef SHIFT_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  int unsigned   idx;
  logic [IW-1:0] cand;

  // Search begins just past the last winner so every requester gets a turn.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (32'(ptr_q) + k) % NREQ;
      cand = IW'(idx);
      if (!grant_valid && req_valid_i[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (xfer) begin
      ptr_q <= grant_id;
    end
  end
`else
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_valid && req_valid_i[IW'(i)]) begin
        grant_valid = 1'b1;
        grant_id    = IW'(i);
      end
    end
  end
`endif

  assign xfer = (state_q == StIdle) && grant_valid;

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StShift;
          // Reset is synchronous, so the grant must also be masked while it is held.
          if (!rst_i) req_ready_o[grant_id] = 1'b1;
        end
      end
      StShift: state_d = StResp;
      StResp: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      op_data_q  <= '0;
      op_amt_q   <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        op_data_q <= data_arr[grant_id];
        op_amt_q  <= amt_arr[grant_id];
        id_q      <= grant_id;
      end
      if (state_q == StShift) rsp_data_q <= sh_shifted_data_i;
    end
  end

  assign sh_datain_o    = op_data_q;
  assign sh_shift_amt_o = op_amt_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_id_o       = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus random traffic checked against a cycle model.
// Honours SHIFT_ARB_RR_EN the same way the design does.
module tb_shift_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int SW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [7:0]      data_a [4];
  logic [2:0]      amt_a  [4];
  logic [31:0]     req_data;
  logic [11:0]     req_amt;
  logic [7:0]      sh_datain;
  logic [2:0]      sh_amt;
  logic [7:0]      sh_shifted;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_data;
  logic            rsp_ready;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    req_amt  = '0;
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = data_a[i];
      req_amt[i*3 +: 3]  = amt_a[i];
    end
  end

  // Shifter stub: left shift truncated to the operand width.
  assign sh_shifted = 8'(sh_datain << sh_amt);

  shift_arbiter #(.NREQ(NREQ), .DW(DW), .SW(SW)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_data_i        (req_data),
    .req_amt_i         (req_amt),
    .sh_datain_o       (sh_datain),
    .sh_shift_amt_o    (sh_amt),
    .sh_shifted_data_i (sh_shifted),
    .rsp_valid_o       (rsp_valid),
    .rsp_id_o          (rsp_id),
    .rsp_data_o        (rsp_data),
    .rsp_ready_i       (rsp_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since the last accept (0 = free, saturates at 2 = answering).
  int         m_age   = 0;
  int         m_ptr   = 3;
  bit         m_known = 1'b0;
  logic [7:0] m_op, m_res, m_rsp;
  logic [2:0] m_amt;
  int         m_id;
  int         acc_w   = -1;

  logic [3:0] obs_ready;
  logic       obs_rv;
  logic [1:0] obs_id;
  logic [7:0] obs_data;
  logic [7:0] obs_sh;

  function automatic int winner(input logic [3:0] v, input int ptr);
`ifdef SHIFT_ARB_RR_EN
    for (int k = 1; k <= 4; k++) if (v[(ptr + k) % 4]) return (ptr + k) % 4;
`else
    for (int i = 0; i < 4; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  // Called with inputs already applied for this cycle; returns one cycle later.
  task automatic cycle();
    int w;
    logic [3:0] exp_rdy;
    #1;
    obs_ready = req_ready;
    obs_rv    = rsp_valid;
    obs_id    = rsp_id;
    obs_data  = rsp_data;
    obs_sh    = sh_datain;
    w = (m_age == 0) ? winner(req_valid, m_ptr) : -1;
    exp_rdy = (w >= 0 && !rst) ? 4'(1 << w) : 4'b0000;
    if (m_known) begin
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(m_age == 2));
      check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
      check_eq("rsp_data", 32'(rsp_data), 32'(m_rsp));
      check_eq("sh_datain", 32'(sh_datain), 32'(m_op));
      check_eq("sh_amt", 32'(sh_amt), 32'(m_amt));
    end
    acc_w = rst ? -1 : w;
    if (rst) begin
      m_age = 0; m_op = '0; m_amt = '0; m_id = 0; m_rsp = '0; m_ptr = 3; m_known = 1'b1;
    end else if (m_age == 0) begin
      if (w >= 0) begin
        m_op  = data_a[w];
        m_amt = amt_a[w];
        m_id  = w;
        m_ptr = w;
        m_res = 8'(data_a[w] << amt_a[w]);
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_rsp = m_res;
      m_age = 2;
    end else if (rsp_ready) begin
      m_age = 0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  int g_cyc [$];
  int g_id  [$];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_a[i] = '0;
      amt_a[i]  = '0;
    end
    @(negedge clk);
    #1;

    // Reset state
    do_reset();
    cycle();
    check_eq("reset_rsp_valid", 32'(obs_rv), 32'd0);
    check_eq("reset_rsp_data", 32'(obs_data), 32'd0);
    check_eq("reset_rsp_id", 32'(obs_id), 32'd0);
    check_eq("reset_sh_datain", 32'(obs_sh), 32'd0);
    check_eq("reset_ready", 32'(obs_ready), 32'd0);

    // Single request
    rsp_ready = 1'b1;
    data_a[1] = 8'hB5; amt_a[1] = 3'd3; req_valid = 4'b0010;
    cycle();
    check_eq("single_ready", 32'(obs_ready), 32'h2);
    req_valid = '0;
    cycle();
    cycle();
    check_eq("single_rsp_valid", 32'(obs_rv), 32'd1);
    check_eq("single_rsp_id", 32'(obs_id), 32'd1);
    check_eq("single_rsp_data", 32'(obs_data), 32'hA8);

    // Shift amount zero
    data_a[2] = 8'h5A; amt_a[2] = 3'd0; req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    check_eq("amt0_rsp_valid", 32'(obs_rv), 32'd1);
    check_eq("amt0_rsp_data", 32'(obs_data), 32'h5A);

    // All requesters valid continuously
    do_reset();
    for (int i = 0; i < 4; i++) begin
      data_a[i] = 8'(8'h11 * (i + 1));
      amt_a[i]  = 3'(i + 1);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      cycle();
      for (int b = 0; b < 4; b++) begin
        if (obs_ready[b]) begin
          g_cyc.push_back(c);
          g_id.push_back(b);
        end
      end
    end
    check_eq("grant_count", 32'(g_cyc.size()), 32'd5);
    for (int k = 0; k < g_cyc.size() && k < 5; k++) begin
      check_eq("grant_cycle", 32'(g_cyc[k]), 32'(3 * k));
`ifdef SHIFT_ARB_RR_EN
      check_eq("grant_id", 32'(g_id[k]), 32'(k % 4));
`else
      check_eq("grant_id", 32'(g_id[k]), 32'd0);
`endif
    end

    // Stalled response
    do_reset();
    data_a[0] = 8'h3C; amt_a[0] = 3'd1; req_valid = 4'b0001;
    rsp_ready = 1'b0;
    cycle();
    req_valid = 4'b1110;
    cycle();
    for (int s = 0; s < 5; s++) begin
      cycle();
      check_eq("stall_rsp_valid", 32'(obs_rv), 32'd1);
      check_eq("stall_rsp_data", 32'(obs_data), 32'h78);
      check_eq("stall_rsp_id", 32'(obs_id), 32'd0);
      check_eq("stall_ready", 32'(obs_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    cycle();
    check_eq("release_ready", 32'(obs_ready), 32'd0);
    cycle();
    check_eq("next_accept", 32'(obs_ready), 32'h2);

    // Reset while shifting
    do_reset();
    data_a[2] = 8'hFF; amt_a[2] = 3'd2; req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check_eq("rstshift_rsp_valid", 32'(obs_rv), 32'd0);
    check_eq("rstshift_rsp_data", 32'(obs_data), 32'd0);
    cycle();
    cycle();
    check_eq("rstshift_no_rsp", 32'(obs_rv), 32'd0);

    // Random traffic
    req_valid = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i]) begin
          if (acc_w == i || $urandom_range(7) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          data_a[i]    = 8'($urandom);
          amt_a[i]     = 3'($urandom);
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      rst       = ($urandom_range(60) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters; the requester index is 2 bits wide.
REQ-002 Parameter: DW, 8, operand/result width.
REQ-003 Parameter: SW, 3, shift-amount width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester request valid.
REQ-007 req_ready  output  NREQ  per-requester accept; at most one bit set.
REQ-008 req_data  input  NREQ*DW  packed operands; requester i at [i*DW +: DW].
REQ-009 req_amt  input  NREQ*SW  packed shift amounts; requester i at [i*SW +: SW].
REQ-010 sh_datain  output  DW  operand to the shared barrel_shifter.
REQ-011 sh_shift_amt  output  SW  shift amount to the shared barrel_shifter.
REQ-012 sh_shifted_data  input  DW  combinational result from the shared barrel_shifter.
REQ-013 rsp_valid  output  1  response valid.
REQ-014 rsp_id  output  2  index of the requester that owns the response.
REQ-015 rsp_data  output  DW  registered shift result.
REQ-016 rsp_ready  input  1  response consumer accept.

Function
REQ-017 FSM states: IDLE, SHIFT, RESP.
- IDLE -> SHIFT when any req_valid is set.
- SHIFT -> RESP unconditionally.
- RESP -> IDLE when rsp_ready is set.
REQ-018 In IDLE, req_ready[w] = 1 for the single winner w, decoded combinationally from req_valid and the arbitration pointer; req_ready = 0 in all other states.
- A transfer occurs when req_valid[i] & req_ready[i] are both set.
- On a transfer, req_data[w], req_amt[w] and w are latched into op_data_q, op_amt_q and id_q.
REQ-019 sh_datain = op_data_q and sh_shift_amt = op_amt_q in every state; both hold their last value between operations.
REQ-020 In SHIFT, sh_shifted_data is captured into rsp_data and id_q is driven on rsp_id.
REQ-021 rsp_valid = 1 only in RESP.
- rsp_data and rsp_id stay stable while rsp_valid = 1 and rsp_ready = 0.
REQ-022 Latency: a transfer at cycle N gives rsp_valid = 1 at cycle N+2; minimum issue interval is 3 cycles.
REQ-023 No new request is accepted in SHIFT or RESP; a stalled response blocks all requesters.
REQ-024 Requesters hold req_valid, req_data and req_amt until accepted.
- A requester may drop req_valid before acceptance with no side effect.
REQ-025 rsp_ready sampled in IDLE or SHIFT has no effect.
REQ-026 Shift amount 0 passes the operand through unchanged, as returned by the shifter.

Reset
REQ-027 On rst = 1 at a clock edge:
- state = IDLE;
- rsp_valid = 0, rsp_id = 0, rsp_data = 0;
- op_data_q = 0, op_amt_q = 0, id_q = 0;
- arbitration pointer = 3.
REQ-028 During rst, req_ready = 0.
REQ-029 Reset asserted in SHIFT or RESP discards the in-flight operation; no response is produced for it.

Configuration
REQ-030 Macro SHIFT_ARB_RR_EN defined: round-robin arbitration.
- Search starts at pointer+1, modulo NREQ.
- The pointer is set to w on every transfer.
REQ-031 SHIFT_ARB_RR_EN undefined: fixed priority, requester 0 highest, requester 3 lowest; the pointer is unused.

Verification
REQ-032 The bench shifter stub returns sh_shifted_data = (sh_datain << sh_shift_amt) truncated to DW bits.
REQ-033 Single request: req_valid = 4'b0010, data 8'hB5, amt 3 -> req_ready = 4'b0010 at cycle N; rsp_valid at N+2 with rsp_id = 1 and rsp_data = 8'hA8.
REQ-034 All four requesters valid continuously, rsp_ready = 1, SHIFT_ARB_RR_EN defined -> grant order 0, 1, 2, 3, 0, with accepts spaced 3 cycles apart.
REQ-035 Same stimulus with SHIFT_ARB_RR_EN undefined -> every grant goes to requester 0.
REQ-036 rsp_ready held at 0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready = 0 throughout; next accept in the cycle after rsp_ready = 1.
REQ-037 rst pulsed in SHIFT -> next cycle state = IDLE, rsp_valid = 0, rsp_data = 0; no response is emitted for the discarded request.
REQ-038 Amount 0 with data 8'h5A -> rsp_data = 8'h5A.
